// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: core and loader share one synchronous single-port memory.
// Fair round-robin on ties, with a bounded exclusive lock for the loader and a core-priority cooldown.
module mem_arbiter #(
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [15:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [15:0] l_addr,
    input  logic [31:0] l_wdata,
    input  logic        l_lock,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] rdata,
    output logic        m_wen,
    output logic        m_ren,
    output logic [15:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a port's access is accepted in the cycle where req=1 and gnt=1;
    // gnt never appears without req, and a granted read returns rvalid/rdata one cycle later.

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic [1:0] {
        ST_ARB      = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_lock_cnt;
    logic            r_last_l;
    logic            r_c_rd_pend;
    logic            r_l_rd_pend;
    logic            w_c_gnt;
    logic            w_l_gnt;
    logic            w_lock_done;

    assign w_lock_done = (r_lock_cnt == CW'(LOCK_MAX - 1));

    // State register, lock counter, round-robin pointer and read-return tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ARB;
            r_lock_cnt  <= '0;
            r_last_l    <= 1'b1;
            r_c_rd_pend <= 1'b0;
            r_l_rd_pend <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_LOCKED && w_next_state == ST_LOCKED) begin
                r_lock_cnt <= r_lock_cnt + CW'(1);
            end else begin
                r_lock_cnt <= '0;
            end
            if (w_c_gnt) begin
                r_last_l <= 1'b0;
            end else if (w_l_gnt) begin
                r_last_l <= 1'b1;
            end
            r_c_rd_pend <= w_c_gnt & ~c_we;
            r_l_rd_pend <= w_l_gnt & ~l_we;
        end
    end

    // Next-state logic; the lock is only taken on a cycle the loader actually wins
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_l_gnt && l_lock) begin
                    w_next_state = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!l_lock) begin
                    w_next_state = ST_ARB;
                end else if (w_lock_done) begin
                    w_next_state = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                w_next_state = ST_ARB;
            end
            default: begin
                w_next_state = ST_ARB;
            end
        endcase
    end

    // Grant decode; everything is held off while reset is asserted
    always_comb begin
        w_c_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_ARB: begin
                    if (c_req && l_req) begin
                        w_c_gnt = r_last_l;
                        w_l_gnt = ~r_last_l;
                    end else begin
                        w_c_gnt = c_req;
                        w_l_gnt = l_req;
                    end
                end
                ST_LOCKED: begin
                    w_l_gnt = l_req;
                end
                ST_COOLDOWN: begin
                    w_c_gnt = c_req;
                    w_l_gnt = l_req & ~c_req;
                end
                default: begin
                    w_c_gnt = 1'b0;
                    w_l_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        m_wen   = 1'b0;
        m_ren   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_c_gnt) begin
            m_wen   = c_we;
            m_ren   = ~c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (w_l_gnt) begin
            m_wen   = l_we;
            m_ren   = ~l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end
    end

    assign c_gnt     = w_c_gnt;
    assign l_gnt     = w_l_gnt;
    // A read in flight is dropped as soon as reset is seen, not one edge later
    assign c_rvalid  = r_c_rd_pend & ~rst;
    assign l_rvalid  = r_l_rd_pend & ~rst;
    assign rdata     = m_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: ties, lock/forced release, write/read, reset mid-read, idle.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [15:0] c_addr = '0;
    logic [31:0] c_wdata = '0;
    logic        l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [15:0] l_addr = '0;
    logic [31:0] l_wdata = '0;
    logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
    logic [31:0] rdata;
    logic        m_wen, m_ren;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:255];
    int checks = 0;
    int failures = 0;

    localparam logic [1:0] S_ARB = 2'd0, S_LOCKED = 2'd1, S_COOL = 2'd2;

    mem_arbiter #(.LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid),
        .rdata(rdata), .m_wen(m_wen), .m_ren(m_ren), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous memory model with one-cycle read latency
    always @(posedge clk) begin
        if (m_wen) mem[m_addr[7:0]] <= m_wdata;
        if (m_ren) m_rdata <= mem[m_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r,
                         input logic cr, input logic cw, input logic [15:0] ca, input logic [31:0] cd,
                         input logic lr, input logic lw, input logic [15:0] la, input logic [31:0] ld,
                         input logic lk);
        @(negedge clk);
        rst = r;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;

        // Reset held with both ports requesting
        drive(1, 1, 0, 16'h1, 0, 1, 0, 16'h2, 0, 0);
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_m_ren", m_ren, 0);
        drive(1, 1, 0, 16'h1, 0, 1, 0, 16'h2, 0, 0);
        chk("rst_state", dbg_state, S_ARB);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);

        // Tie reads right after reset: C, L, C, L
        drive(0, 1, 0, 16'h1, 0, 1, 0, 16'h2, 0, 0);
        chk("tie1_c_gnt", c_gnt, 1);
        chk("tie1_l_gnt", l_gnt, 0);
        chk("tie1_m_ren", m_ren, 1);
        chk("tie1_m_addr", m_addr, 16'h1);
        drive(0, 1, 0, 16'h3, 0, 1, 0, 16'h4, 0, 0);
        chk("tie2_l_gnt", l_gnt, 1);
        chk("tie2_c_gnt", c_gnt, 0);
        chk("tie2_m_ren", m_ren, 1);
        chk("tie2_m_addr", m_addr, 16'h4);
        chk("tie2_c_rvalid", c_rvalid, 1);
        chk("tie2_l_rvalid", l_rvalid, 0);
        chk("tie2_rdata", rdata, 32'hA000_0001);
        drive(0, 1, 0, 16'h5, 0, 1, 0, 16'h6, 0, 0);
        chk("tie3_c_gnt", c_gnt, 1);
        chk("tie3_m_addr", m_addr, 16'h5);
        chk("tie3_l_rvalid", l_rvalid, 1);
        chk("tie3_c_rvalid", c_rvalid, 0);
        chk("tie3_rdata", rdata, 32'hA000_0004);
        drive(0, 1, 0, 16'h7, 0, 1, 0, 16'h8, 0, 0);
        chk("tie4_l_gnt", l_gnt, 1);
        chk("tie4_m_ren", m_ren, 1);
        chk("tie4_m_addr", m_addr, 16'h8);
        chk("tie4_c_rvalid", c_rvalid, 1);
        chk("tie4_rdata", rdata, 32'hA000_0005);

        // Idle
        drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
        chk("idle_l_rvalid", l_rvalid, 1);
        chk("idle_rdata", rdata, 32'hA000_0008);
        chk("idle_m_wen", m_wen, 0);
        chk("idle_m_ren", m_ren, 0);
        chk("idle_m_addr", m_addr, 0);
        chk("idle_m_wdata", m_wdata, 0);
        chk("idle_c_gnt", c_gnt, 0);
        chk("idle_l_gnt", l_gnt, 0);
        drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
        chk("idle2_c_rvalid", c_rvalid, 0);
        chk("idle2_l_rvalid", l_rvalid, 0);

        // Core-only write then read back
        drive(0, 1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 16'h0, 0, 0);
        chk("wr_c_gnt", c_gnt, 1);
        chk("wr_m_wen", m_wen, 1);
        chk("wr_m_ren", m_ren, 0);
        chk("wr_m_addr", m_addr, 16'h0010);
        chk("wr_m_wdata", m_wdata, 32'hDEADBEEF);
        drive(0, 1, 0, 16'h0010, 0, 0, 0, 16'h0, 0, 0);
        chk("rd_c_gnt", c_gnt, 1);
        chk("rd_m_ren", m_ren, 1);
        chk("rd_m_wen", m_wen, 0);
        chk("wr_no_rvalid", c_rvalid, 0);
        drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
        chk("rd_c_rvalid", c_rvalid, 1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("rd_l_rvalid", l_rvalid, 0);

        // Lock for three cycles then release; core was granted last so loader wins the tie
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0030, 32'h11, 1);
        chk("lk_entry_l_gnt", l_gnt, 1);
        chk("lk_entry_c_gnt", c_gnt, 0);
        chk("lk_entry_m_wen", m_wen, 1);
        chk("lk_entry_m_addr", m_addr, 16'h0030);
        chk("lk_entry_state", dbg_state, S_ARB);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0030, 32'h11, 1);
        chk("lk1_state", dbg_state, S_LOCKED);
        chk("lk1_l_gnt", l_gnt, 1);
        chk("lk1_c_gnt", c_gnt, 0);
        drive(0, 1, 0, 16'h0020, 0, 0, 1, 16'h0030, 32'h11, 1);
        chk("lk2_gap_l_gnt", l_gnt, 0);
        chk("lk2_gap_c_gnt", c_gnt, 0);
        chk("lk2_gap_m_wen", m_wen, 0);
        chk("lk2_state", dbg_state, S_LOCKED);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0030, 32'h11, 0);
        chk("lk3_state", dbg_state, S_LOCKED);
        chk("lk3_l_gnt", l_gnt, 1);
        chk("lk3_c_gnt", c_gnt, 0);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0030, 32'h11, 0);
        chk("unlk_state", dbg_state, S_ARB);
        chk("unlk_c_gnt", c_gnt, 1);
        chk("unlk_l_gnt", l_gnt, 0);

        // Forced release with LOCK_MAX=4, lock held for ten cycles
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 1);
        chk("fr_entry_l_gnt", l_gnt, 1);
        chk("fr_entry_state", dbg_state, S_ARB);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 1);
            chk("fr_locked_state", dbg_state, S_LOCKED);
            chk("fr_locked_l_gnt", l_gnt, 1);
            chk("fr_locked_c_gnt", c_gnt, 0);
        end
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 1);
        chk("cool_state", dbg_state, S_COOL);
        chk("cool_c_gnt", c_gnt, 1);
        chk("cool_l_gnt", l_gnt, 0);
        chk("cool_m_ren", m_ren, 1);
        chk("cool_m_addr", m_addr, 16'h0020);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 1);
        chk("post_cool_state", dbg_state, S_ARB);
        chk("post_cool_l_gnt", l_gnt, 1);
        chk("post_cool_c_rvalid", c_rvalid, 1);
        chk("post_cool_l_rvalid", l_rvalid, 0);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 1);
        chk("relock_state", dbg_state, S_LOCKED);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 1);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 1);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 0);
        chk("relock_drop_state", dbg_state, S_LOCKED);
        drive(0, 1, 0, 16'h0020, 0, 1, 1, 16'h0031, 32'h22, 0);
        chk("relock_exit_state", dbg_state, S_ARB);
        chk("relock_exit_c_gnt", c_gnt, 1);

        // Reset arriving while a loader read is in flight
        drive(0, 0, 0, 16'h0, 0, 1, 0, 16'h0009, 0, 0);
        chk("rr_l_gnt", l_gnt, 1);
        chk("rr_m_ren", m_ren, 1);
        drive(1, 1, 0, 16'h0001, 0, 1, 0, 16'h0009, 0, 0);
        chk("rr_rst_l_rvalid", l_rvalid, 0);
        chk("rr_rst_c_gnt", c_gnt, 0);
        chk("rr_rst_l_gnt", l_gnt, 0);
        chk("rr_rst_m_ren", m_ren, 0);
        drive(0, 1, 0, 16'h0001, 0, 1, 0, 16'h0009, 0, 0);
        chk("rr_after_state", dbg_state, S_ARB);
        chk("rr_after_l_rvalid", l_rvalid, 0);
        chk("rr_after_c_gnt", c_gnt, 1);
        chk("rr_after_l_gnt", l_gnt, 0);
        drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0);
        chk("rr_final_c_rvalid", c_rvalid, 1);
        chk("rr_final_l_rvalid", l_rvalid, 0);
        chk("rr_final_rdata", rdata, 32'hA000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
